// File: rtl/dense_reader_if.sv
// Memory-side bus of the fully-connected layer: POOL, weight and bias ROM reads,
// logits buffer writes, plus the start/done sequencing pair.
interface dense_reader_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IN_DIM     = 1568,
    parameter int unsigned OUT_DIM    = 10
);
    localparam int unsigned InAw  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int unsigned WAw   = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1;
    localparam int unsigned OutAw = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    logic                         start;
    logic                         done;
    logic [InAw-1:0]              in_addr;
    logic                         in_en;
    logic signed [DATA_WIDTH-1:0] in_q;
    logic [WAw-1:0]               w_addr;
    logic                         w_en;
    logic signed [DATA_WIDTH-1:0] w_q;
    logic [OutAw-1:0]             b_addr;
    logic                         b_en;
    logic signed [DATA_WIDTH-1:0] b_q;
    logic [OutAw-1:0]             out_addr;
    logic                         out_en;
    logic                         out_we;
    logic signed [DATA_WIDTH-1:0] out_d;

    modport master (
        input  start, in_q, w_q, b_q,
        output done, in_addr, in_en, w_addr, w_en, b_addr, b_en,
               out_addr, out_en, out_we, out_d
    );

    modport slave (
        output start, in_q, w_q, b_q,
        input  done, in_addr, in_en, w_addr, w_en, b_addr, b_en,
               out_addr, out_en, out_we, out_d
    );
endinterface

// File: rtl/dense_reader.sv
// Fully-connected layer: streams the pooled vector against each weight row, adds the
// aligned bias and writes one saturated logit per neuron in ascending order.
module dense_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 7,
    parameter int unsigned IN_DIM     = 1568,
    parameter int unsigned OUT_DIM    = 10
) (
    input logic            clk,
    input logic            reset,
    dense_reader_if.master bus
);
    localparam int unsigned InAw  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int unsigned WAw   = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1;
    localparam int unsigned OutAw = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int unsigned AccW  = 2 * DATA_WIDTH + $clog2(IN_DIM) + 1;
    localparam int unsigned PrdW  = 2 * DATA_WIDTH;

    localparam logic [InAw-1:0]  LastIn  = InAw'(IN_DIM - 1);
    localparam logic [OutAw-1:0] LastOut = OutAw'(OUT_DIM - 1);

    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] OutMax = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OutMin = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StWrite, StFinish} state_e;

    state_e                       r_state;
    logic [InAw-1:0]              r_in_addr;
    logic                         r_in_en;
    logic [WAw-1:0]               r_w_addr;
    logic                         r_w_en;
    logic [OutAw-1:0]             r_b_addr;
    logic                         r_b_en;
    logic [OutAw-1:0]             r_out_addr;
    logic                         r_out_en;
    logic                         r_out_we;
    logic signed [DATA_WIDTH-1:0] r_out_d;
    logic                         r_done;
    logic signed [AccW-1:0]       r_acc;
    logic                         r_vld;
    logic                         r_first;

    state_e                       w_state_nxt;
    logic [InAw-1:0]              w_in_addr_nxt;
    logic                         w_in_en_nxt;
    logic [WAw-1:0]               w_w_addr_nxt;
    logic                         w_w_en_nxt;
    logic [OutAw-1:0]             w_b_addr_nxt;
    logic                         w_b_en_nxt;
    logic [OutAw-1:0]             w_out_addr_nxt;
    logic                         w_out_en_nxt;
    logic                         w_out_we_nxt;
    logic signed [DATA_WIDTH-1:0] w_out_d_nxt;
    logic                         w_done_nxt;

    logic signed [PrdW-1:0]       w_prod;
    logic signed [AccW-1:0]       w_prod_ext;
    logic signed [AccW-1:0]       w_bias_ext;
    logic signed [AccW-1:0]       w_acc_nxt;
    logic signed [AccW-1:0]       w_shift;
    logic signed [DATA_WIDTH-1:0] w_sat;

    // Read data lags its enable by one cycle, so r_vld/r_first trail in_en/b_en by one.
    assign w_prod     = bus.in_q * bus.w_q;
    assign w_prod_ext = {{(AccW - PrdW){w_prod[PrdW-1]}}, w_prod};
    assign w_bias_ext = {{(AccW - DATA_WIDTH){bus.b_q[DATA_WIDTH-1]}}, bus.b_q} <<< FRAC_BITS;
    assign w_acc_nxt  = r_vld ? ((r_first ? w_bias_ext : r_acc) + w_prod_ext) : r_acc;
    assign w_shift    = w_acc_nxt >>> FRAC_BITS;

    always_comb begin
        if (w_shift > SatMax) begin
            w_sat = OutMax;
        end else if (w_shift < SatMin) begin
            w_sat = OutMin;
        end else begin
            w_sat = w_shift[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_in_addr_nxt  = r_in_addr;
        w_in_en_nxt    = 1'b0;
        w_w_addr_nxt   = r_w_addr;
        w_w_en_nxt     = 1'b0;
        w_b_addr_nxt   = r_b_addr;
        w_b_en_nxt     = 1'b0;
        w_out_addr_nxt = r_out_addr;
        w_out_en_nxt   = 1'b0;
        w_out_we_nxt   = 1'b0;
        w_out_d_nxt    = r_out_d;
        w_done_nxt     = 1'b0;

        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_in_addr_nxt = '0;
                    w_w_addr_nxt  = '0;
                    w_b_addr_nxt  = '0;
                    w_in_en_nxt   = 1'b1;
                    w_w_en_nxt    = 1'b1;
                    w_b_en_nxt    = 1'b1;
                    w_state_nxt   = StMac;
                end
            end
            StMac: begin
                // r_in_addr doubles as the element index of the current row.
                if (r_in_addr == LastIn) begin
                    w_state_nxt = StWrite;
                end else begin
                    w_in_addr_nxt = r_in_addr + InAw'(1);
                    w_w_addr_nxt  = r_w_addr + WAw'(1);
                    w_in_en_nxt   = 1'b1;
                    w_w_en_nxt    = 1'b1;
                end
            end
            StWrite: begin
                w_out_addr_nxt = r_b_addr;
                w_out_en_nxt   = 1'b1;
                w_out_we_nxt   = 1'b1;
                w_out_d_nxt    = w_sat;
                if (r_b_addr != LastOut) begin
                    w_in_addr_nxt = '0;
                    w_w_addr_nxt  = r_w_addr + WAw'(1);
                    w_b_addr_nxt  = r_b_addr + OutAw'(1);
                    w_in_en_nxt   = 1'b1;
                    w_w_en_nxt    = 1'b1;
                    w_b_en_nxt    = 1'b1;
                    w_state_nxt   = StMac;
                end else begin
                    w_state_nxt = StFinish;
                end
            end
            StFinish: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_addr  <= '0;
            r_in_en    <= 1'b0;
            r_w_addr   <= '0;
            r_w_en     <= 1'b0;
            r_b_addr   <= '0;
            r_b_en     <= 1'b0;
            r_out_addr <= '0;
            r_out_en   <= 1'b0;
            r_out_we   <= 1'b0;
            r_out_d    <= '0;
            r_done     <= 1'b0;
            r_acc      <= '0;
            r_vld      <= 1'b0;
            r_first    <= 1'b0;
        end else begin
            r_in_addr  <= w_in_addr_nxt;
            r_in_en    <= w_in_en_nxt;
            r_w_addr   <= w_w_addr_nxt;
            r_w_en     <= w_w_en_nxt;
            r_b_addr   <= w_b_addr_nxt;
            r_b_en     <= w_b_en_nxt;
            r_out_addr <= w_out_addr_nxt;
            r_out_en   <= w_out_en_nxt;
            r_out_we   <= w_out_we_nxt;
            r_out_d    <= w_out_d_nxt;
            r_done     <= w_done_nxt;
            r_acc      <= w_acc_nxt;
            r_vld      <= r_in_en;
            r_first    <= r_b_en;
        end
    end

    assign bus.in_addr  = r_in_addr;
    assign bus.in_en    = r_in_en;
    assign bus.w_addr   = r_w_addr;
    assign bus.w_en     = r_w_en;
    assign bus.b_addr   = r_b_addr;
    assign bus.b_en     = r_b_en;
    assign bus.out_addr = r_out_addr;
    assign bus.out_en   = r_out_en;
    assign bus.out_we   = r_out_we;
    assign bus.out_d    = r_out_d;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_dense_reader.sv
// Scoreboard bench for dense_reader: three small configurations (plain, 8-bit saturating,
// Q.7 single-input) driven with directed and random vectors against an arithmetic model.
module tb_dense_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] tb_start = '0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    typedef struct {
        int     addr;
        longint data;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t exp_c[$];
    int   log_in[$];
    int   log_w[$];
    int   log_b[$];

    dense_reader_if #(.DATA_WIDTH(16), .IN_DIM(4), .OUT_DIM(2)) ifa ();
    dense_reader_if #(.DATA_WIDTH(8),  .IN_DIM(4), .OUT_DIM(2)) ifb ();
    dense_reader_if #(.DATA_WIDTH(16), .IN_DIM(1), .OUT_DIM(2)) ifc ();

    dense_reader #(.DATA_WIDTH(16), .FRAC_BITS(0), .IN_DIM(4), .OUT_DIM(2)) dut_a (
        .clk(clk), .reset(rst), .bus(ifa)
    );
    dense_reader #(.DATA_WIDTH(8), .FRAC_BITS(0), .IN_DIM(4), .OUT_DIM(2)) dut_b (
        .clk(clk), .reset(rst), .bus(ifb)
    );
    dense_reader #(.DATA_WIDTH(16), .FRAC_BITS(7), .IN_DIM(1), .OUT_DIM(2)) dut_c (
        .clk(clk), .reset(rst), .bus(ifc)
    );

    assign ifa.start = tb_start[0];
    assign ifb.start = tb_start[1];
    assign ifc.start = tb_start[2];

    logic signed [15:0] x_a[4];
    logic signed [15:0] w_a[8];
    logic signed [15:0] b_a[2];
    logic signed [7:0]  x_b[4];
    logic signed [7:0]  w_b[8];
    logic signed [7:0]  b_b[2];
    logic signed [15:0] x_c;
    logic signed [15:0] w_c[2];
    logic signed [15:0] b_c[2];

    // Synchronous ROM/RAM models: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (ifa.in_en) ifa.in_q <= x_a[ifa.in_addr];
        if (ifa.w_en)  ifa.w_q  <= w_a[ifa.w_addr];
        if (ifa.b_en)  ifa.b_q  <= b_a[ifa.b_addr];
        if (ifb.in_en) ifb.in_q <= x_b[ifb.in_addr];
        if (ifb.w_en)  ifb.w_q  <= w_b[ifb.w_addr];
        if (ifb.b_en)  ifb.b_q  <= b_b[ifb.b_addr];
        if (ifc.in_en) ifc.in_q <= x_c;
        if (ifc.w_en)  ifc.w_q  <= w_c[ifc.w_addr];
        if (ifc.b_en)  ifc.b_q  <= b_c[ifc.b_addr];
    end

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int pending(input int k);
        case (k)
            0:       return exp_a.size();
            1:       return exp_b.size();
            default: return exp_c.size();
        endcase
    endfunction

    function automatic exp_t pop(input int k);
        case (k)
            0:       return exp_a.pop_front();
            1:       return exp_b.pop_front();
            default: return exp_c.pop_front();
        endcase
    endfunction

    function automatic logic get_done(input int k);
        case (k)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    function automatic int rnd(input int lim);
        return int'($urandom_range(2 * lim)) - lim;
    endfunction

    // Reference: exact dot product, floor division by 2^fb, clamp to the signed range.
    function automatic longint ref_out(input longint acc, input int dw, input int fb);
        longint s  = acc >>> fb;
        longint mx = (longint'(1) << (dw - 1)) - 1;
        longint mn = -(longint'(1) << (dw - 1));
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
    endfunction

    task automatic push_a();
        for (int o = 0; o < 2; o++) begin
            longint acc = longint'(b_a[o]);
            for (int i = 0; i < 4; i++) acc += longint'(x_a[i]) * longint'(w_a[o * 4 + i]);
            exp_a.push_back('{o, ref_out(acc, 16, 0)});
        end
    endtask

    task automatic push_b();
        for (int o = 0; o < 2; o++) begin
            longint acc = longint'(b_b[o]);
            for (int i = 0; i < 4; i++) acc += longint'(x_b[i]) * longint'(w_b[o * 4 + i]);
            exp_b.push_back('{o, ref_out(acc, 8, 0)});
        end
    endtask

    task automatic push_c();
        for (int o = 0; o < 2; o++) begin
            longint acc = longint'(b_c[o]) * 128 + longint'(x_c) * longint'(w_c[o]);
            exp_c.push_back('{o, ref_out(acc, 16, 7)});
        end
    endtask

    task automatic mon_write(input int k, input logic en, input int addr, input longint d);
        exp_t  e;
        string nm = (k == 0) ? "A" : ((k == 1) ? "B" : "C");
        check({nm, " out_en with out_we"}, longint'(en), 1);
        if (pending(k) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s unexpected write: addr %0d data %0d, required no write", nm, addr, d);
        end else begin
            e = pop(k);
            check({nm, " out_addr"}, longint'(addr), longint'(e.addr));
            check({nm, " out_d"}, d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.out_we) mon_write(0, ifa.out_en, int'(ifa.out_addr), longint'(ifa.out_d));
        if (ifb.out_we) mon_write(1, ifb.out_en, int'(ifb.out_addr), longint'(ifb.out_d));
        if (ifc.out_we) mon_write(2, ifc.out_en, int'(ifc.out_addr), longint'(ifc.out_d));
        if (ifa.in_en) begin
            log_in.push_back(int'(ifa.in_addr));
            log_w.push_back(int'(ifa.w_addr));
        end
        if (ifa.b_en) log_b.push_back(int'(ifa.b_addr));
    end

    // One pass: pulse start, bound the wait for done, check latency and pulse width.
    task automatic run_pass(input int k, input int exp_cycles, input bit noisy);
        int cnt  = 0;
        bit seen = 1'b0;
        @(negedge clk);
        tb_start[k] = 1'b1;
        @(negedge clk);
        tb_start[k] = 1'b0;
        while (cnt < 200 && !seen) begin
            @(posedge clk);
            #1;
            cnt++;
            if (get_done(k)) seen = 1'b1;
            tb_start[k] = noisy && !seen &&
                          (cnt == 1 || cnt == 4 || cnt == 6 || cnt == 9 || cnt == 10);
        end
        tb_start[k] = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL pass %0d timeout: no done within %0d cycles, required %0d", k, cnt,
                     exp_cycles);
        end else begin
            check("done latency", longint'(cnt), longint'(exp_cycles));
            @(posedge clk);
            #1;
            check("done one cycle", longint'(get_done(k)), 0);
        end
        check("writes outstanding", longint'(pending(k)), 0);
    endtask

    task automatic idle_no_done(input int k, input int cycles);
        int hits = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (get_done(k)) hits++;
        end
        check("spurious done", longint'(hits), 0);
    endtask

    task automatic rand_a(input int lim);
        foreach (x_a[i]) x_a[i] = 16'(rnd(lim));
        foreach (w_a[i]) w_a[i] = 16'(rnd(lim));
        foreach (b_a[i]) b_a[i] = 16'(rnd(lim));
    endtask

    initial begin
        #3;
        check("reset A outputs", longint'({ifa.in_en, ifa.w_en, ifa.b_en, ifa.out_en, ifa.out_we,
              ifa.done, ifa.in_addr, ifa.w_addr, ifa.b_addr, ifa.out_addr, ifa.out_d}), 0);
        check("reset C outputs", longint'({ifc.in_en, ifc.w_en, ifc.b_en, ifc.out_en, ifc.out_we,
              ifc.done, ifc.w_addr, ifc.b_addr, ifc.out_addr, ifc.out_d}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed dot products with read-address sequence.
        x_a = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        w_a = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, -16'sd1, 16'sd0, 16'sd0, 16'sd2};
        b_a = '{16'sd0, 16'sd5};
        log_in.delete();
        log_w.delete();
        log_b.delete();
        push_a();
        run_pass(0, 11, 1'b0);
        check("in_addr reads", longint'(log_in.size()), 8);
        check("w_addr reads", longint'(log_w.size()), 8);
        check("b_addr reads", longint'(log_b.size()), 2);
        for (int t = 0; t < 8; t++) begin
            if (t < log_in.size()) check("in_addr seq", longint'(log_in[t]), longint'(t % 4));
            if (t < log_w.size()) check("w_addr seq", longint'(log_w[t]), longint'(t));
        end
        for (int t = 0; t < 2; t++) begin
            if (t < log_b.size()) check("b_addr seq", longint'(log_b[t]), longint'(t));
        end

        // 8-bit saturation on both rails.
        x_b = '{8'sd100, 8'sd100, 8'sd100, 8'sd100};
        w_b = '{8'sd100, 8'sd100, 8'sd100, 8'sd100, -8'sd100, -8'sd100, -8'sd100, -8'sd100};
        b_b = '{8'sd0, 8'sd0};
        push_b();
        run_pass(1, 11, 1'b0);

        // Q.7 fraction and floor toward minus infinity.
        x_c = 16'sd64;
        w_c = '{16'sd64, 16'sd1};
        b_c = '{16'sd0, 16'sd0};
        push_c();
        run_pass(2, 5, 1'b0);
        x_c = -16'sd1;
        push_c();
        run_pass(2, 5, 1'b0);

        // Bias alignment with zero input.
        x_c = 16'sd0;
        b_c = '{-16'sd3, 16'sd7};
        push_c();
        run_pass(2, 5, 1'b0);
        b_c = '{16'sd128, -16'sd128};
        push_c();
        run_pass(2, 5, 1'b0);

        // Start pulses during MAC, WRITE and FINISH must not restart the pass.
        rand_a(200);
        push_a();
        run_pass(0, 11, 1'b1);
        idle_no_done(0, 15);

        // Asynchronous reset in the middle of neuron 1.
        rand_a(300);
        push_a();
        @(negedge clk);
        tb_start[0] = 1'b1;
        @(negedge clk);
        tb_start[0] = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid-pass reset outputs", longint'({ifa.in_en, ifa.w_en, ifa.b_en, ifa.out_en,
              ifa.out_we, ifa.done, ifa.in_addr, ifa.w_addr, ifa.b_addr, ifa.out_addr,
              ifa.out_d}), 0);
        check("writes before reset", longint'(pending(0)), 1);
        exp_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_no_done(0, 20);
        push_a();
        run_pass(0, 11, 1'b0);

        // Random passes across all configurations.
        for (int n = 0; n < 6; n++) begin
            rand_a((n % 2 == 0) ? 250 : 32767);
            push_a();
            run_pass(0, 11, n == 3);
        end
        for (int n = 0; n < 3; n++) begin
            foreach (x_b[i]) x_b[i] = 8'(rnd((n == 0) ? 10 : 127));
            foreach (w_b[i]) w_b[i] = 8'(rnd((n == 0) ? 10 : 127));
            foreach (b_b[i]) b_b[i] = 8'(rnd(127));
            push_b();
            run_pass(1, 11, 1'b0);
        end
        for (int n = 0; n < 6; n++) begin
            x_c = 16'(rnd((n % 2 == 0) ? 400 : 32767));
            foreach (w_c[i]) w_c[i] = 16'(rnd((n % 2 == 0) ? 400 : 32767));
            foreach (b_c[i]) b_c[i] = 16'(rnd((n % 2 == 0) ? 300 : 32767));
            push_c();
            run_pass(2, 5, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
